// File: rtl/rf_write_arbiter_if.sv
// Writeback / MDU / register-file write-port bundle for rf_write_arbiter.
interface rf_write_arbiter_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
);
    // Writeback stage request (absolute priority, never stalled)
    logic             wb_we;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;

    // MDU result handshake
    logic             mdu_valid;
    logic [4:0]       mdu_addr;
    logic [31:0]      mdu_data;
    logic             mdu_ready;

    // Register file write port
    logic             rf_we;
    logic [4:0]       rf_addr;
    logic [31:0]      rf_wd;

    // Status towards decode / observability
    logic [31:0]      rf_pending;
    logic [PTR_W:0]   fifo_count;

    // Arbiter side
    modport slave (
        input  wb_we, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        output mdu_ready,
        output rf_we, rf_addr, rf_wd,
        output rf_pending, fifo_count
    );

    // Requester / environment side
    modport master (
        output wb_we, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready,
        input  rf_we, rf_addr, rf_wd,
        input  rf_pending, fifo_count
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between writeback (priority)
// and the MDU, which is buffered in a small in-order FIFO with WAW kill.
module rf_write_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rf_write_arbiter_if.slave    bus
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam int unsigned NREG  = 32;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               ready_q,  ready_d;
    logic [NREG-1:0]    pending_q, pending_d;

    logic               wb_active;
    logic               fifo_empty;
    entry_t             head;
    logic               head_live;
    logic               use_head;
    logic               bypass;
    logic               pop;
    logic               accept;
    logic               enq;

    // Request decode shared by the port mux and the FIFO next-state logic
    always_comb begin
        wb_active  = bus.wb_we & (bus.wb_addr != '0);
        fifo_empty = (count_q == '0);
        head       = mem_q[rd_ptr_q];
        head_live  = ~fifo_empty & head.valid;
        use_head   = ~wb_active & head_live;
        bypass     = ~wb_active & fifo_empty & bus.mdu_valid & (bus.mdu_addr != '0);
        // A killed head leaves without the port, even while writeback owns it
        pop        = ~fifo_empty & (use_head | ~head.valid);
        accept     = bus.mdu_valid & ready_q;
        // Writeback to the same register makes the incoming result stale
        enq        = accept & ~bypass & (bus.mdu_addr != '0)
                   & ~(wb_active & (bus.mdu_addr == bus.wb_addr));
    end

    // Write-port mux: writeback, then FIFO head, then empty-FIFO bypass
    always_comb begin
        bus.rf_we   = 1'b0;
        bus.rf_addr = '0;
        bus.rf_wd   = '0;
        if (wb_active) begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = bus.wb_addr;
            bus.rf_wd   = bus.wb_data;
        end else if (head_live) begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = head.addr;
            bus.rf_wd   = head.data;
        end else if (bypass) begin
            bus.rf_we   = 1'b1;
            bus.rf_addr = bus.mdu_addr;
            bus.rf_wd   = bus.mdu_data;
        end
    end

    // FIFO next state: kill matching entries, retire head, append new result
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
            if (wb_active && mem_q[i].valid && (mem_q[i].addr == bus.wb_addr)) begin
                mem_d[i].valid = 1'b0;
            end
        end
        if (pop) begin
            mem_d[rd_ptr_q].valid = 1'b0;
        end
        if (enq) begin
            mem_d[wr_ptr_q].valid = 1'b1;
            mem_d[wr_ptr_q].addr  = bus.mdu_addr;
            mem_d[wr_ptr_q].data  = bus.mdu_data;
        end
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        count_d  = count_q + CNT_W'(enq) - CNT_W'(pop);
        // No same-cycle pop credit: ready follows the resulting occupancy
        ready_d  = (count_d != CNT_W'(DEPTH));
    end

    // Pending vector built from the next queue contents so it is registered
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (mem_d[i].valid) begin
                pending_d[mem_d[i].addr] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    // State registers; reset discards all queued results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            pending_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            pending_q <= pending_d;
        end
    end

    assign bus.mdu_ready  = ready_q;
    assign bus.rf_pending = pending_q;
    assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a queue model.
module tb_rf_write_arbiter;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst_n;

    rf_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

    rf_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: arrival-ordered list of accepted results; killed ones stay as dead slots
    typedef struct {
        bit          live;
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Predict this cycle's outputs from the queue, compare, then advance the queue
    task automatic model_cycle();
        bit          wb_act, full, byp, store, pop;
        logic        exp_we;
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        logic [31:0] pend;
        wb_act = bus.wb_we && (bus.wb_addr != 5'd0);
        full   = (q.size() >= DEPTH);
        pend   = '0;
        foreach (q[i]) if (q[i].live) pend[q[i].a] = 1'b1;
        pend[0] = 1'b0;
        chk("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
        chk("mdu_ready", 64'(bus.mdu_ready), 64'(!full));
        chk("rf_pending", 64'(bus.rf_pending), 64'(pend));
        exp_we = 1'b0; exp_a = '0; exp_d = '0; byp = 0;
        if (wb_act) begin
            exp_we = 1'b1; exp_a = bus.wb_addr; exp_d = bus.wb_data;
        end else if (q.size() > 0 && q[0].live) begin
            exp_we = 1'b1; exp_a = q[0].a; exp_d = q[0].d;
        end else if (q.size() == 0 && bus.mdu_valid && bus.mdu_addr != 5'd0) begin
            exp_we = 1'b1; exp_a = bus.mdu_addr; exp_d = bus.mdu_data; byp = 1;
        end
        chk("rf_we", 64'(bus.rf_we), 64'(exp_we));
        chk("rf_addr", 64'(bus.rf_addr), 64'(exp_a));
        chk("rf_wd", 64'(bus.rf_wd), 64'(exp_d));
        pop   = (q.size() > 0) && (!q[0].live || !wb_act);
        store = bus.mdu_valid && !full && !byp && (bus.mdu_addr != 5'd0)
                && !(wb_act && bus.mdu_addr == bus.wb_addr);
        if (wb_act) foreach (q[i]) if (q[i].a == bus.wb_addr) q[i].live = 0;
        if (pop) void'(q.pop_front());
        if (store) q.push_back('{live: 1, a: bus.mdu_addr, d: bus.mdu_data});
    endtask

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
        @(negedge clk);
        bus.wb_we     = we;
        bus.wb_addr   = wa;
        bus.wb_data   = wd;
        bus.mdu_valid = mv;
        bus.mdu_addr  = ma;
        bus.mdu_data  = md;
        #1;
        model_cycle();
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.wb_we     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.mdu_valid = 1'b0;
        bus.mdu_addr  = '0;
        bus.mdu_data  = '0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_ready", 64'(bus.mdu_ready), 64'd1);
        chk("rst_pending", 64'(bus.rf_pending), 64'd0);
        chk("rst_rf_we_idle", 64'(bus.rf_we), 64'd0);
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd9;
        #1;
        chk("rst_rf_we_follows_wb", 64'(bus.rf_we), 64'd1);
        bus.wb_we   = 1'b0;
        bus.wb_addr = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: bypass on idle port with empty FIFO
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("t1_we", 64'(bus.rf_we), 64'd1);
        chk("t1_addr", 64'(bus.rf_addr), 64'd5);
        chk("t1_wd", 64'(bus.rf_wd), 64'hDEAD_BEEF);
        idle();
        chk("t1_count", 64'(bus.fifo_count), 64'd0);

        // 2: fill while writeback is busy, then drain in order
        for (int i = 0; i < 4; i++)
            step(1'b1, 5'd3, 32'h33 + 32'(i), 1'b1, 5'(7 + i), 32'h700 + 32'(i));
        idle();
        chk("t2_count_full", 64'(bus.fifo_count), 64'd4);
        chk("t2_ready_full", 64'(bus.mdu_ready), 64'd0);
        chk("t2_pending", 64'(bus.rf_pending), 64'h780);
        chk("t2_drain0", 64'(bus.rf_addr), 64'd7);
        for (int i = 1; i < 4; i++) begin
            idle();
            chk("t2_drain", 64'(bus.rf_addr), 64'(7 + i));
        end
        idle();
        chk("t2_pending_clear", 64'(bus.rf_pending), 64'd0);
        chk("t2_ready_back", 64'(bus.mdu_ready), 64'd1);

        // 3: queued result killed by a later writeback to the same register
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'h11);
        step(1'b1, 5'd12, 32'h22, 1'b0, 5'd0, 32'd0);
        chk("t3_wb_wins", 64'(bus.rf_wd), 64'h22);
        chk("t3_pend12_set", 64'(bus.rf_pending[12]), 64'd1);
        idle();
        chk("t3_pend12_clear", 64'(bus.rf_pending[12]), 64'd0);
        chk("t3_killed_slot", 64'(bus.fifo_count), 64'd1);
        chk("t3_killed_no_write", 64'(bus.rf_we), 64'd0);
        idle();
        chk("t3_empty", 64'(bus.fifo_count), 64'd0);

        // 4: same-cycle collision on one register
        step(1'b1, 5'd4, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB);
        chk("t4_wd", 64'(bus.rf_wd), 64'hAAAA);
        chk("t4_ready", 64'(bus.mdu_ready), 64'd1);
        idle();
        chk("t4_count", 64'(bus.fifo_count), 64'd0);
        chk("t4_no_late_write", 64'(bus.rf_we), 64'd0);

        // 5: register 0 from both sources
        step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
        chk("t5_we", 64'(bus.rf_we), 64'd0);
        idle();
        chk("t5_count", 64'(bus.fifo_count), 64'd0);
        chk("t5_pend0", 64'(bus.rf_pending[0]), 64'd0);

        // Randomized traffic over a small register set to provoke kills and fills
        repeat (400) begin
            step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom());
        end

        // 6: asynchronous reset with three entries queued
        repeat (8) idle();
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd13, 32'hD);
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd14, 32'hE);
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd15, 32'hF);
        @(negedge clk);
        bus.wb_we     = 1'b1;
        bus.wb_addr   = 5'd1;
        bus.wb_data   = 32'h77;
        bus.mdu_valid = 1'b0;
        #1;
        chk("t6_count_before", 64'(bus.fifo_count), 64'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_count", 64'(bus.fifo_count), 64'd0);
        chk("t6_ready", 64'(bus.mdu_ready), 64'd1);
        chk("t6_pending", 64'(bus.rf_pending), 64'd0);
        chk("t6_rf_we", 64'(bus.rf_we), 64'd1);
        chk("t6_rf_wd", 64'(bus.rf_wd), 64'h77);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            idle();
            chk("t6_no_stale_write", 64'(bus.rf_we), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the register file's single write port (WE/A3/WD3, written on negedge clk) between two requesters. The pipeline writeback stage has absolute priority and is never stalled. The long-latency multiply/divide unit (MDU) delivers results through a valid/ready handshake into a small FIFO, which drains only in cycles where writeback leaves the port idle. The block also publishes a per-register pending vector so decode can stall on registers still waiting for an MDU result.

Parameters:
DEPTH, 4, MDU result FIFO entries (power of 2, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
clk  in  1  system clock; state updates on posedge
rst_n  in  1  asynchronous active-low reset
wb_we  in  1  writeback stage write request
wb_addr  in  5  writeback destination register
wb_data  in  32  writeback data
mdu_valid  in  1  MDU result valid
mdu_addr  in  5  MDU destination register
mdu_data  in  32  MDU result
mdu_ready  out  1  FIFO can accept (= !full)
rf_we  out  1  to register file WE
rf_addr  out  5  to register file A3
rf_wd  out  32  to register file WD3
rf_pending  out  32  bit r = 1 while a valid queued entry targets r; bit 0 always 0
fifo_count  out  PTR_W+1  occupied FIFO slots, including killed slots

Behaviour:
- Reset (async, rst_n=0): rd/wr pointers = 0, count = 0, all entry valid bits = 0.
  - Resulting outputs: mdu_ready=1, rf_pending=0, fifo_count=0, rf_we=wb_we (combinational).
  - Reset mid-operation discards all queued results with no write.
- wb_active = wb_we & (wb_addr != 0).
- Port mux (combinational, same cycle as inputs):
  - wb_active: rf_we=1, rf_addr=wb_addr, rf_wd=wb_data.
  - else if head valid: rf_we=1 with head addr/data; head pops at posedge.
  - else if FIFO empty, mdu_valid and mdu_addr != 0: bypass. rf_we=1 with mdu addr/data; accepted with nothing enqueued.
  - else: rf_we=0, rf_addr=0, rf_wd=0.
- Invalid (killed) head: popped at posedge in any cycle, without using the port.
  - Costs one cycle; a bypass is not allowed that cycle because the FIFO is not empty.
- Enqueue: on mdu_valid & mdu_ready when not bypassed.
  - mdu_addr==0: accepted and dropped, nothing stored.
  - Otherwise written at wr_ptr with valid=1.
  - mdu_ready = !full. No same-cycle pop credit: a full FIFO deasserts ready even while draining.
- Kill rule (WAW protection): when wb_active, every queued valid entry with addr==wb_addr is cleared at posedge.
  - An incoming MDU result the same cycle with mdu_addr==wb_addr is accepted but dropped. Writeback always wins.
- Simultaneous enqueue + pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- rf_pending: OR over valid entries of the one-hot decode of addr, taken from registered state only.
  - It does not include the current-cycle mdu input.
  - It clears the cycle after the entry drains or is killed.
- Latency:
  - Writeback: 0 cycles.
  - MDU: 0 cycles on bypass; otherwise at least 1 cycle plus the number of writeback-busy cycles ahead of it.
  - No starvation bound is guaranteed if writeback is active every cycle.
- FIFO order is strict: entries drain in arrival order.

Test Plan:
1. Reset then idle, mdu_valid=1, addr=5, data=0xDEADBEEF, wb_we=0 -> same cycle rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF; fifo_count stays 0.
2. wb_we=1, addr=3, held for 4 cycles; MDU sends addr 7, 8, 9, 10 -> FIFO fills and mdu_ready=0 at count=4; rf_pending=0x00000780; after wb_we drops, writes to 7, 8, 9, 10 appear on consecutive cycles; then rf_pending=0 and mdu_ready=1.
3. Queue addr 12 (data 0x11) while writeback is busy, then wb_we=1 to addr 12 (data 0x22) -> rf_pending[12] clears next cycle; 0x11 is never written; the killed head takes one idle cycle with rf_we=0.
4. Same cycle: wb_we=1 addr 4 and mdu_valid=1 addr 4 -> rf_wd=wb_data; MDU handshake completes; FIFO is unchanged and no later write to 4 occurs.
5. mdu_valid with addr 0 and wb_we with addr 0 -> rf_we=0, nothing enqueued, rf_pending[0]=0.
6. Assert rst_n=0 asynchronously with 3 entries queued -> outputs go to reset values immediately (fifo_count=0, rf_pending=0, mdu_ready=1); no queued write appears after release.
